cbu16_capture: RTL and testbench

Input-capture / compare unit that consumes the 16-bit count of a free-running up counter (Q15..Q0 of the 16-bit counter macro) and time-stamps external events against it. An asynchronous event input is synchronised, edge-qualified, and the counter value at the event is pushed into a 2-entry capture buffer drained through a valid/ready handshake. A compare register produces a single-cycle match pulse when the count reaches a programmed value. Sits directly downstream of the counter in timer/period-measurement macros.

---
 rtl/cbu16_capture_pkg.sv | 15 +
 rtl/cbu16_capture_if.sv | 14 +
 rtl/cbu16_capture_sync.sv | 61 ++++++
 rtl/cbu16_capture.sv | 112 +++++++++++
 tb/tb_cbu16_capture.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cbu16_capture_pkg.sv
// Shared definitions for the cbu16 capture/compare unit: edge-select encoding
// and default data width / buffer depth.
package cbu16_capture_pkg;

  localparam int unsigned CBU_WIDTH = 16;
  localparam int unsigned CBU_DEPTH = 2;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

endpackage

// File: rtl/cbu16_capture_if.sv
// Capture-buffer drain channel (valid/ready).
//   data  : head-of-buffer captured count
//   valid : buffer non-empty
//   ready : consumer accepts head when valid & ready
interface cbu16_capture_if #(
  parameter int unsigned WIDTH = cbu16_capture_pkg::CBU_WIDTH
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/cbu16_capture_sync.sv
// Event front end: synchronises cap_in_i, detects edges selected by
// edge_sel_i and holds events off until the synchroniser has flushed after
// reset.
//   clk, rst_n  : clock, async active-low reset
//   cap_in_i    : asynchronous event input
//   edge_sel_i  : none / rising / falling / both
//   evt_c_o     : one-cycle event strobe (combinational from flops)
module cbu16_capture_sync
  import cbu16_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap_in_i,
  input  logic [1:0] edge_sel_i,
  output logic       evt_c_o
);

  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [ARM_W-1:0]       arm_cnt_q;
  logic                   armed_c;
  logic                   rise_c;
  logic                   fall_c;

  // Armed once ARM_CYCLES edges have passed since reset release, so a level
  // already high at reset never looks like an edge.
  assign armed_c = (arm_cnt_q == ARM_W'(ARM_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cap_in_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!armed_c) arm_cnt_q <= arm_cnt_q + ARM_W'(1);
    end
  end

  assign rise_c =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] &  prev_q;

  // Edge qualify
  always_comb begin
    evt_c_o = 1'b0;
    unique case (edge_sel_i)
      EDGE_RISE: evt_c_o = rise_c;
      EDGE_FALL: evt_c_o = fall_c;
      EDGE_BOTH: evt_c_o = rise_c | fall_c;
      default:   evt_c_o = 1'b0;
    endcase
    evt_c_o = evt_c_o & armed_c;
  end

endmodule

// File: rtl/cbu16_capture.sv
// Input-capture / compare unit time-stamping events against a free-running
// count. Captures go into a 2-entry buffer drained over cap_if; a compare
// pulse fires on the rising edge of (cmp_en_i & cnt_i == cmp_val_i).
//   clk, rst_n   : clock, async active-low reset
//   cnt_i        : counter value
//   cap_in_i     : asynchronous event input
//   edge_sel_i   : event edge select
//   cap_if       : captured-count drain channel (master)
//   ovr_o        : sticky overflow, event lost with buffer full
//   ovr_clr_i    : synchronous clear of ovr_o (set wins)
//   cmp_val_i    : compare value
//   cmp_en_i     : compare enable
//   cmp_match_o  : one-cycle match pulse
module cbu16_capture
  import cbu16_capture_pkg::*;
#(
  parameter int unsigned WIDTH       = CBU_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        cnt_i,
  input  logic                    cap_in_i,
  input  logic [1:0]              edge_sel_i,
  cbu16_capture_if.master         cap_if,
  output logic                    ovr_o,
  input  logic                    ovr_clr_i,
  input  logic [WIDTH-1:0]        cmp_val_i,
  input  logic                    cmp_en_i,
  output logic                    cmp_match_o
);

  localparam int unsigned CNT_W = $clog2(CBU_DEPTH + 1);

  logic             evt_c;
  logic             pop_c;
  logic             full_c;
  logic             match_c;

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             match_prev_q;
  logic             cmp_match_q, cmp_match_d;

  cbu16_capture_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_in_i   (cap_in_i),
    .edge_sel_i (edge_sel_i),
    .evt_c_o    (evt_c)
  );

  assign pop_c   = valid_q & cap_if.ready;
  assign full_c  = (count_q == CNT_W'(CBU_DEPTH));
  assign match_c = cmp_en_i & (cnt_i == cmp_val_i);

  // Buffer kept as a shift pair so the head is always a flop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_c && evt_c) begin
      if (count_q == CNT_W'(1)) begin
        head_d = cnt_i;
      end else begin
        head_d = tail_q;
        tail_d = cnt_i;
      end
    end else if (pop_c) begin
      head_d  = tail_q;
      count_d = count_q - CNT_W'(1);
    end else if (evt_c && !full_c) begin
      if (count_q == '0) head_d = cnt_i;
      else               tail_d = cnt_i;
      count_d = count_q + CNT_W'(1);
    end
    valid_d     = (count_d != '0);
    ovr_d       = (evt_c & full_c & ~pop_c) | (ovr_q & ~ovr_clr_i);
    cmp_match_d = match_c & ~match_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
      match_prev_q <= 1'b0;
      cmp_match_q  <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
      match_prev_q <= match_c;
      cmp_match_q  <= cmp_match_d;
    end
  end

  assign cap_if.data  = head_q;
  assign cap_if.valid = valid_q;
  assign ovr_o        = ovr_q;
  assign cmp_match_o  = cmp_match_q;

endmodule

// File: tb/tb_cbu16_capture.sv
module tb_cbu16_capture;
  import cbu16_capture_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned SS = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] cnt = '0;
  logic         cap_in = 1'b0;
  logic [1:0]   edge_sel = EDGE_NONE;
  logic         ovr;
  logic         ovr_clr = 1'b0;
  logic [W-1:0] cmp_val = '0;
  logic         cmp_en = 1'b0;
  logic         cmp_match;
  bit           cnt_run = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int match_pulses = 0;

  cbu16_capture_if #(.WIDTH(W)) cap_if ();

  cbu16_capture #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_i       (cnt),
    .cap_in_i    (cap_in),
    .edge_sel_i  (edge_sel),
    .cap_if      (cap_if),
    .ovr_o       (ovr),
    .ovr_clr_i   (ovr_clr),
    .cmp_val_i   (cmp_val),
    .cmp_en_i    (cmp_en),
    .cmp_match_o (cmp_match)
  );

  always #5 clk = ~clk;

  // Reference model: event at edge k compares the input sampled SS edges
  // earlier against the one before it; buffer is a plain queue.
  logic [W-1:0] mq[$];
  bit m_ovr, m_match, m_prev;
  bit h1, h2, h3;
  int edge_k;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 0; m_match = 0; m_prev = 0;
    h1 = 0; h2 = 0; h3 = 0;
    edge_k = 0;
  endtask

  task automatic model_edge();
    bit cur, prv, ev, pop, m;
    int pre;
    edge_k++;
    cur = h2; prv = h3;
    ev = 0;
    if (edge_k >= int'(SS) + 2) begin
      if (edge_sel[0] && cur && !prv) ev = 1;
      if (edge_sel[1] && !cur && prv) ev = 1;
    end
    pre = mq.size();
    pop = (pre > 0) && cap_if.ready;
    if (pop) void'(mq.pop_front());
    if (ev) begin
      if (pre == 2 && !pop) m_ovr = 1;
      else mq.push_back(cnt);
    end else if (ovr_clr) begin
      m_ovr = 0;
    end
    if (ev && pre == 2 && !pop) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
    m = cmp_en && (cnt == cmp_val);
    m_match = m && !m_prev;
    m_prev = m;
    h3 = h2; h2 = h1; h1 = cap_in;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check("cap_valid", 32'(cap_if.valid), 32'(mq.size() > 0));
    if (mq.size() > 0) check("cap_data", 32'(cap_if.data), 32'(mq[0]));
    check("ovr", 32'(ovr), 32'(m_ovr));
    check("cmp_match", 32'(cmp_match), 32'(m_match));
    if (cmp_match) match_pulses++;
    if (cnt_run) cnt = cnt + W'(1);
  endtask

  task automatic rand_phase(input int n, input int ready_pct, input int cap_pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < cap_pct) cap_in = ~cap_in;
      cap_if.ready = ($urandom_range(99) < ready_pct);
      ovr_clr = ($urandom_range(15) == 0);
      if ($urandom_range(19) == 0) edge_sel = 2'($urandom_range(3));
      if ($urandom_range(9) == 0) cmp_en = ~cmp_en;
      if ($urandom_range(7) == 0) cmp_val = cnt + W'($urandom_range(8));
      cnt_run = ($urandom_range(7) != 0);
      step();
    end
    cnt_run = 1;
  endtask

  logic [W-1:0] saved;

  initial begin
    model_reset();
    cap_if.ready = 1'b0;
    // Reset with cap_in already high
    cap_in = 1'b1;
    edge_sel = EDGE_BOTH;
    repeat (3) step();
    check("rst_valid", 32'(cap_if.valid), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_match", 32'(cmp_match), 32'd0);
    rst_n = 1'b1;
    repeat (5) begin
      step();
      check("arm_valid", 32'(cap_if.valid), 32'd0);
    end

    // Rising capture at cnt 0x0105 -> stored 0x0107
    cap_in = 1'b0;
    edge_sel = EDGE_RISE;
    repeat (4) step();
    cnt = 16'h0100;
    while (cnt != 16'h0105) step();
    cap_in = 1'b1;
    step(); step();
    check("rise_lat2", 32'(cap_if.valid), 32'd0);
    step();
    check("rise_valid", 32'(cap_if.valid), 32'd1);
    check("rise_data", 32'(cap_if.data), 32'h0107);
    cap_in = 1'b0;
    repeat (4) step();
    check("fall_ignored", 32'(mq.size()), 32'd1);
    cap_if.ready = 1'b1;
    step();
    cap_if.ready = 1'b0;
    check("drained", 32'(cap_if.valid), 32'd0);

    // Both edges, no drain: two held, third dropped
    edge_sel = EDGE_BOTH;
    repeat (3) begin
      cap_in = ~cap_in;
      repeat (3) step();
    end
    check("ovr_set", 32'(ovr), 32'd1);
    check("full_cnt", 32'(mq.size()), 32'd2);
    // Clear coinciding with a fourth drop: set wins
    cap_in = ~cap_in;
    step(); step();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_setwins", 32'(ovr), 32'd1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(ovr), 32'd0);

    // Full, pop and event on the same edge
    saved = mq[1];
    cap_in = ~cap_in;
    step(); step();
    cap_if.ready = 1'b1;
    step();
    cap_if.ready = 1'b0;
    check("pp_ovr", 32'(ovr), 32'd0);
    check("pp_head", 32'(cap_if.data), 32'(saved));
    check("pp_count", 32'(mq.size()), 32'd2);
    cap_if.ready = 1'b1;
    repeat (3) step();
    cap_if.ready = 1'b0;

    // Compare across wrap, then paused at the match
    edge_sel = EDGE_NONE;
    cmp_val = 16'h0000;
    cnt = 16'hFFFC;
    cmp_en = 1'b1;
    match_pulses = 0;
    while (cnt != 16'h0000) step();
    cnt_run = 0;
    repeat (10) step();
    cnt_run = 1;
    repeat (5) step();
    check("wrap_pulses", 32'(match_pulses), 32'd1);
    cmp_en = 1'b0;
    step();

    rand_phase(600, 60, 30);
    rand_phase(400, 15, 40);
    rand_phase(400, 90, 50);

    // Mid-operation reset with the buffer full and overflow set
    edge_sel = EDGE_BOTH;
    cap_if.ready = 1'b0;
    repeat (4) begin
      cap_in = ~cap_in;
      repeat (3) step();
    end
    check("pre_rst_full", 32'(cap_if.valid), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", 32'(cap_if.valid), 32'd0);
    check("arst_ovr", 32'(ovr), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    rand_phase(300, 50, 35);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
